// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: double-buffered VGA framebuffer controller.
// Pixel writes go to the back bank. The front bank is scanned out at an integer
// upscale. The banks swap at the start of vertical blank when a swap is requested.
// Optional build macro VGA_FB_TESTPAT_EN adds input tp_en and an 8-bar colour test pattern.
module vga_fb_ctrl #(
    parameter int RES_X       = 320,
    parameter int RES_Y       = 240,
    parameter int SCALE       = 2,
    parameter int PIXEL_WIDTH = 4,
    parameter int CLK_DIV     = 2,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(RES_X)-1:0] wr_x,
    input  logic [$clog2(RES_Y)-1:0] wr_y,
    input  logic [7:0]               wr_data,
    output logic                     wr_oob,
    input  logic                     swap_req,
    output logic                     swap_done,
    output logic                     front_sel,
    output logic [15:0]              frame_cnt,
`ifdef VGA_FB_TESTPAT_EN
    input  logic                     tp_en,
`endif
    output logic [PIXEL_WIDTH-1:0]   vga_r,
    output logic [PIXEL_WIDTH-1:0]   vga_g,
    output logic [PIXEL_WIDTH-1:0]   vga_b,
    output logic                     h_sync,
    output logic                     v_sync,
    output logic                     vga_active
);
    localparam int H_ACTIVE = RES_X * SCALE;
    localparam int V_ACTIVE = RES_Y * SCALE;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int XW       = $clog2(RES_X);
    localparam int SW       = $clog2(SCALE) + 1;
    localparam int DW       = $clog2(CLK_DIV) + 1;
    localparam int DEPTH    = 2 * RES_X * RES_Y;
    localparam int AW       = $clog2(DEPTH);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_BLANK  = VW'(V_ACTIVE);
    localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(RES_X - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(RES_X);
    localparam logic [AW-1:0] ROW_LAST = AW'((RES_Y - 1) * RES_X);
    localparam logic [AW-1:0] BANK1    = AW'(RES_X * RES_Y);

    // Replicate a 2-bit channel across the full DAC width (2'b10 -> 4'b1010).
    function automatic logic [PIXEL_WIDTH-1:0] expand2(input logic [1:0] c);
        logic [PIXEL_WIDTH-1:0] r;
        for (int i = 0; i < PIXEL_WIDTH; i++) begin
            r[i] = (i % 2 == 1) ? c[1] : c[0];
        end
        return r;
    endfunction

    logic [DW-1:0] div_q;
    logic          pix_en;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [SW-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
    logic [XW-1:0] col_q, col_d;
    logic [AW-1:0] rowb_q, rowb_d;
    logic          front_q, pending_q, pending_d, oob_q, done_q;
    logic [15:0]   frame_q;
    logic [7:0]    ram_q [DEPTH];
    logic [AW-1:0] scan_addr, wr_addr, addr_p1;
    logic          wr_fire, oob_hit, vblank_start;
    logic          act_s, hs_s, vs_s, act_p1, hs_p1, vs_p1;
    logic [5:0]    px_s;
`ifdef VGA_FB_TESTPAT_EN
    logic          tp_p1;
    logic [2:0]    bar_p1;
`endif

    assign pix_en       = (div_q == DIV_LAST);
    assign vblank_start = pix_en && (h_q == '0) && (v_q == V_BLANK);
    assign wr_ready     = !pending_q;
    assign wr_fire      = wr_valid && wr_ready;
    assign oob_hit      = (int'(wr_x) >= RES_X) || (int'(wr_y) >= RES_Y);
    assign wr_addr      = (front_q ? '0 : BANK1) + AW'(wr_y) * ROW_STEP + AW'(wr_x);
    assign scan_addr    = (front_q ? BANK1 : '0) + rowb_q + AW'(col_q);
    assign act_s        = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    assign hs_s         = !((int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC));
    assign vs_s         = !((int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC));
    assign wr_oob       = oob_q;
    assign swap_done    = done_q;
    assign front_sel    = front_q;
    assign frame_cnt    = frame_q;

    // Raster counters plus the divider-free column/row-base trackers for the scan address.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        hsub_d = hsub_q;
        vsub_d = vsub_q;
        col_d  = col_q;
        rowb_d = rowb_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d    = '0;
                hsub_d = '0;
                col_d  = '0;
                if (v_q == V_LAST) begin
                    v_d    = '0;
                    vsub_d = '0;
                    rowb_d = '0;
                end else begin
                    v_d = v_q + VW'(1);
                    if (vsub_q == S_LAST) begin
                        vsub_d = '0;
                        if (rowb_q != ROW_LAST) rowb_d = rowb_q + ROW_STEP;
                    end else begin
                        vsub_d = vsub_q + SW'(1);
                    end
                end
            end else begin
                h_d = h_q + HW'(1);
                if (hsub_q == S_LAST) begin
                    hsub_d = '0;
                    if (col_q != X_LAST) col_d = col_q + XW'(1);
                end else begin
                    hsub_d = hsub_q + SW'(1);
                end
            end
        end
    end

    // Swap request is latched once and held until the next vblank start.
    always_comb begin
        pending_d = pending_q;
        if (pending_q) begin
            if (vblank_start) pending_d = 1'b0;
        end else begin
            pending_d = swap_req;
        end
    end

    // Control state: pixel-enable divider, raster counters, bank select and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            hsub_q    <= '0;
            vsub_q    <= '0;
            col_q     <= '0;
            rowb_q    <= '0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            oob_q     <= 1'b0;
            frame_q   <= '0;
        end else begin
            div_q     <= pix_en ? '0 : div_q + DW'(1);
            h_q       <= h_d;
            v_q       <= v_d;
            hsub_q    <= hsub_d;
            vsub_q    <= vsub_d;
            col_q     <= col_d;
            rowb_q    <= rowb_d;
            pending_q <= pending_d;
            front_q   <= front_q ^ (pending_q && vblank_start);
            done_q    <= pending_q && vblank_start;
            oob_q     <= oob_q || (wr_fire && oob_hit);
            if (vblank_start) frame_q <= frame_q + 16'd1;
        end
    end

    // Back-bank write; out-of-range writes are accepted but never reach the RAM.
    always_ff @(posedge clk) begin
        if (wr_fire && !oob_hit) ram_q[wr_addr] <= wr_data;
    end

    // Stage 1 timing flags, aligned with the registered scan address.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_p1 <= 1'b0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
        end else begin
            act_p1 <= act_s;
            hs_p1  <= hs_s;
            vs_p1  <= vs_s;
        end
    end

    // Stage 1 data: scan address (and test-pattern bar index when built in).
    always_ff @(posedge clk) begin
        addr_p1 <= scan_addr;
`ifdef VGA_FB_TESTPAT_EN
        tp_p1   <= tp_en;
        bar_p1  <= 3'((int'(h_q) * 8) / H_ACTIVE);
`endif
    end

    // Select the pixel source for the output stage.
    always_comb begin
        px_s = ram_q[addr_p1][5:0];
`ifdef VGA_FB_TESTPAT_EN
        if (tp_p1) px_s = {bar_p1[2], bar_p1[2], bar_p1[1], bar_p1[1], bar_p1[0], bar_p1[0]};
`endif
    end

    // Stage 2: synchronous RAM read into the registered VGA outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            h_sync     <= 1'b1;
            v_sync     <= 1'b1;
            vga_active <= 1'b0;
        end else begin
            h_sync     <= hs_p1;
            v_sync     <= vs_p1;
            vga_active <= act_p1;
            vga_r      <= act_p1 ? expand2(px_s[5:4]) : '0;
            vga_g      <= act_p1 ? expand2(px_s[3:2]) : '0;
            vga_b      <= act_p1 ? expand2(px_s[1:0]) : '0;
        end
    end
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb_vga_fb_ctrl: directed bench for vga_fb_ctrl using a reduced screen geometry.
module tb_vga_fb_ctrl;
    localparam int RX = 6, RY = 5, SC = 2, CD = 2, PW = 4;
    localparam int HFP = 2, HSY = 3, HBP = 2, VFP = 1, VSY = 2, VBP = 1;
    localparam int HA = RX * SC, HT = HA + HFP + HSY + HBP;
    localparam int VA = RY * SC, VT = VA + VFP + VSY + VBP;
    localparam int FP = HT * VT;
    localparam int XW = $clog2(RX), YW = $clog2(RY);

    logic          clk = 1'b0, rst = 1'b1;
    logic          wr_valid = 1'b0, swap_req = 1'b0;
    logic [XW-1:0] wr_x = '0;
    logic [YW-1:0] wr_y = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_ready, wr_oob, swap_done, front_sel, h_sync, v_sync, vga_active;
    logic [15:0]   frame_cnt;
    logic [PW-1:0] vga_r, vga_g, vga_b;
`ifdef VGA_FB_TESTPAT_EN
    logic          tp_en = 1'b0;
`endif

    typedef struct {
        int   cyc;
        logic hs;
        logic vs;
        logic act;
        int   fc;
    } tv_t;

    tv_t        tv [17];
    logic [7:0] bank1_m [RX*RY];
    int         cyc = 0, n_pass = 0, n_tot = 0, fc0 = 0;
    logic       done_seen = 1'b0, ready_bad = 1'b0;

    vga_fb_ctrl #(
        .RES_X(RX), .RES_Y(RY), .SCALE(SC), .PIXEL_WIDTH(PW), .CLK_DIV(CD),
        .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_oob(wr_oob),
        .swap_req(swap_req), .swap_done(swap_done), .front_sel(front_sel),
        .frame_cnt(frame_cnt),
`ifdef VGA_FB_TESTPAT_EN
        .tp_en(tp_en),
`endif
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .h_sync(h_sync), .v_sync(v_sync), .vga_active(vga_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (swap_done) done_seen = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, got, exp, cyc);
    endtask

    function automatic logic [3:0] ex(input logic [1:0] c);
        return {c, c};
    endfunction

    // Expected {h_sync, v_sync, active, r, g, b} for output cycle c (two-cycle lag).
    function automatic logic [14:0] model(input int c, input bit tp);
        int         p, pos, h, v;
        logic       hs, vs, act;
        logic [5:0] d;
        logic [2:0] bar;
        logic [11:0] rgb;
        if (c < 2) return {1'b1, 1'b1, 1'b0, 12'h000};
        p   = (c - 2) / 2;
        pos = p % FP;
        h   = pos % HT;
        v   = pos / HT;
        act = (h < HA) && (v < VA);
        hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        rgb = 12'h000;
        if (act) begin
            d = bank1_m[(v / SC) * RX + (h / SC)][5:0];
            if (tp) begin
                bar = 3'((h * 8) / HA);
                d   = {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]};
            end
            rgb = {ex(d[5:4]), ex(d[3:2]), ex(d[1:0])};
        end
        return {hs, vs, act, rgb};
    endfunction

    task automatic run_table();
        for (int i = 0; i < 17; i++) begin
            while (cyc < tv[i].cyc) tick();
            chk("h_sync", 32'(h_sync), 32'(tv[i].hs));
            chk("v_sync", 32'(v_sync), 32'(tv[i].vs));
            chk("vga_active", 32'(vga_active), 32'(tv[i].act));
            chk("frame_cnt", 32'(frame_cnt), 32'(tv[i].fc));
            if (!tv[i].act) chk("rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'(0));
        end
    endtask

    task automatic run_scan(input int n, input bit tp);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("scan", 32'({h_sync, v_sync, vga_active, vga_r, vga_g, vga_b}), 32'(model(cyc, tp)));
        end
    endtask

    task automatic wr(input int x, input int y, input logic [7:0] d);
        wr_x     = XW'(x);
        wr_y     = YW'(y);
        wr_data  = d;
        wr_valid = 1'b1;
        chk("wr_ready", 32'(wr_ready), 32'(1));
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        int i;
        i = 0;
        while (((cyc / 2) % FP) != target && i < 2 * FP) begin
            tick();
            i++;
        end
        chk("wait_pos", 32'((cyc / 2) % FP), 32'(target));
    endtask

    initial begin
        tv[0]  = '{1,   1'b1, 1'b1, 1'b0, 0};
        tv[1]  = '{2,   1'b1, 1'b1, 1'b1, 0};
        tv[2]  = '{25,  1'b1, 1'b1, 1'b1, 0};
        tv[3]  = '{26,  1'b1, 1'b1, 1'b0, 0};
        tv[4]  = '{29,  1'b1, 1'b1, 1'b0, 0};
        tv[5]  = '{30,  1'b0, 1'b1, 1'b0, 0};
        tv[6]  = '{35,  1'b0, 1'b1, 1'b0, 0};
        tv[7]  = '{36,  1'b1, 1'b1, 1'b0, 0};
        tv[8]  = '{344, 1'b1, 1'b1, 1'b1, 0};
        tv[9]  = '{381, 1'b1, 1'b1, 1'b0, 0};
        tv[10] = '{382, 1'b1, 1'b1, 1'b0, 1};
        tv[11] = '{419, 1'b1, 1'b1, 1'b0, 1};
        tv[12] = '{420, 1'b1, 1'b0, 1'b0, 1};
        tv[13] = '{448, 1'b0, 1'b0, 1'b0, 1};
        tv[14] = '{495, 1'b1, 1'b0, 1'b0, 1};
        tv[15] = '{496, 1'b1, 1'b1, 1'b0, 1};
        tv[16] = '{534, 1'b1, 1'b1, 1'b1, 1};

        // Reset state
        repeat (3) tick();
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(0));
        chk("rst_syncs", 32'({h_sync, v_sync, vga_active}), 32'(3'b110));
        chk("rst_status", 32'({front_sel, swap_done, wr_oob, wr_ready}), 32'(4'b0001));
        chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));

        // First frame timing
        rst = 1'b0;
        cyc = 0;
        run_table();

        // Fill the back bank, then out-of-range writes, then one targeted pixel
        for (int y = 0; y < RY; y++) begin
            for (int x = 0; x < RX; x++) begin
                bank1_m[y*RX+x] = 8'(((x + RX * y) * 13 + 7) & 63);
                wr(x, y, bank1_m[y*RX+x]);
            end
        end
        chk("oob_clear", 32'(wr_oob), 32'(0));
        wr(RX, 0, 8'hFF);
        chk("oob_x", 32'(wr_oob), 32'(1));
        wr(0, RY, 8'hFF);
        chk("oob_sticky", 32'(wr_oob), 32'(1));
        wr(4, 3, 8'h30);
        bank1_m[3*RX+4] = 8'h30;
        chk("oob_stays", 32'(wr_oob), 32'(1));

        // Swap requested on line 2, a second request while pending is ignored
        wait_pos(2 * HT);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("ready_pending", 32'(wr_ready), 32'(0));
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        fc0 = int'(frame_cnt);
        for (int i = 0; i < 2 * FP; i++) begin
            tick();
            if (swap_done) break;
            if (wr_ready !== 1'b0) ready_bad = 1'b1;
        end
        chk("swap_done", 32'(swap_done), 32'(1));
        chk("swap_at_vblank", 32'(cyc % (2 * FP)), 32'(2 * (VA * HT + 1)));
        chk("ready_held_low", 32'(ready_bad), 32'(0));
        chk("front_sel_swap", 32'(front_sel), 32'(1));
        chk("frame_cnt_swap", 32'(frame_cnt), 32'(fc0 + 1));
        chk("ready_after_swap", 32'(wr_ready), 32'(1));
        tick();
        chk("swap_done_pulse", 32'(swap_done), 32'(0));

        // Write into the new back bank; the displayed bank must be unaffected
        wr(0, 0, 8'h3F);
        done_seen = 1'b0;
        run_scan(600, 1'b0);
        chk("no_double_swap", 32'(done_seen), 32'(0));
        chk("front_sel_hold", 32'(front_sel), 32'(1));

        // Mid-frame reset with a swap pending
        wait_pos(6 * HT);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("ready_pending2", 32'(wr_ready), 32'(0));
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(0));
        chk("mid_rst_syncs", 32'({h_sync, v_sync, vga_active}), 32'(3'b110));
        chk("mid_rst_status", 32'({front_sel, swap_done, wr_oob, wr_ready}), 32'(4'b0001));
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'(0));
        rst = 1'b0;
        cyc = 0;
        done_seen = 1'b0;
        run_table();
        chk("aborted_swap", 32'(done_seen), 32'(0));
        chk("front_sel_after_rst", 32'(front_sel), 32'(0));

`ifdef VGA_FB_TESTPAT_EN
        // Colour bars replace RAM data with unchanged timing
        tp_en = 1'b1;
        repeat (3) tick();
        run_scan(2 * FP + 8, 1'b1);
        tp_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/vga_fb_ctrl.md
Name: vga_fb_ctrl

Overview:
Parametrised double-buffered VGA framebuffer controller, successor to the single-buffer VGA memory block.
- Owns a dual-bank pixel RAM.
- Accepts pixel writes over a valid/ready port into the back bank.
- Scans the front bank out at an integer upscale with registered, mutually aligned sync/RGB outputs.
- Swaps banks atomically at vertical blank on request.

Parameters:
RES_X, 320, framebuffer width in pixels
RES_Y, 240, framebuffer height in pixels
SCALE, 2, integer upscale factor; H_ACTIVE = RES_X*SCALE, V_ACTIVE = RES_Y*SCALE
PIXEL_WIDTH, 4, bits per VGA colour channel
CLK_DIV, 2, clk cycles per VGA pixel (pixel enable period)
H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal porch and sync widths in pixels
V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porch and sync widths in lines

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_x  in  $clog2(RES_X)  write column
wr_y  in  $clog2(RES_Y)  write row
wr_data  in  8  pixel, format 0b00RRGGBB
wr_oob  out  1  sticky: an out-of-range write was dropped
swap_req  in  1  request front/back swap at next vblank
swap_done  out  1  one-cycle pulse when the swap occurs
front_sel  out  1  bank currently displayed
frame_cnt  out  16  frames completed, wraps
vga_r, vga_g, vga_b  out  PIXEL_WIDTH each  colour outputs
h_sync, v_sync  out  1  active-low syncs
vga_active  out  1  visible-region flag

Behaviour:
- Reset: counters=0, front_sel=0 (back bank=1), frame_cnt=0, wr_oob=0, swap_done=0, swap pending cleared, rgb=0, vga_active=0, h_sync=1, v_sync=1. RAM contents are not cleared.
- Pixel enable pulses one clk cycle every CLK_DIV cycles. The first pulse is at cycle CLK_DIV-1 after reset release.
- Horizontal total is H_ACTIVE+H_FP+H_SYNC+H_BP; vertical total is analogous. Order is active, front porch, sync, back porch, all counted from 0.
- h_sync is low for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). v_sync uses the same rule on v_count.
- Scan address: bank*RES_X*RES_Y + (v_count/SCALE)*RES_X + h_count/SCALE.
  - The quotients come from SCALE sub-counters and row/column counters; no dividers.
  - The row base is kept as an accumulator of RES_X; no multiplier in the scan path.
- Pipeline: address register, then synchronous RAM read. All VGA outputs are registered.
- Latency: rgb, h_sync, v_sync and vga_active all lag the counter state by exactly 2 clk cycles and stay mutually aligned.
- Colour expansion: each 2-bit channel is replicated to PIXEL_WIDTH (e.g. 2'b10 becomes 4'b1010). rgb=0 when not active.
- Write port:
  - Address = back*RES_X*RES_Y + wr_y*RES_X + wr_x.
  - The write lands on the clk edge where wr_valid & wr_ready.
  - If wr_x>=RES_X or wr_y>=RES_Y, the write is accepted, discarded, and sets wr_oob (cleared only by rst).
- Swap:
  - swap_req sampled high with no swap pending sets pending. swap_req while pending is ignored.
  - wr_ready = !pending, so no write can straddle the swap.
  - At the pixel-enable cycle where h_count=0 and v_count=V_ACTIVE (vblank start): front_sel toggles, pending clears, swap_done pulses for that cycle.
  - If swap_req arrives on that same cycle with nothing pending, it waits for the next vblank.
- frame_cnt increments at every vblank start, swap or not, and wraps at 0xFFFF->0.
- rst mid-frame aborts the frame and a pending swap. All outputs return to reset values on the next edge.

Optional Feature:
VGA_FB_TESTPAT_EN:
- Defined: adds input tp_en (1 bit). When tp_en=1, RAM data in the output stage is replaced by 8 vertical colour bars, bar index = (h_count*8)/H_ACTIVE, colour = {idx[2],idx[2],idx[1],idx[1],idx[0],idx[0]}. Sync/active timing and latency are unchanged; writes still proceed.
- Undefined: no tp_en port; output is RAM data only.

Test Plan:
1. Release rst with defaults and run one frame -> first h_sync falling edge 2*656+2=1314 clk after release, low 192 clk. v_sync low on lines 490-491. Frame period 840000 clk.
2. Write (x=10, y=5, 0x30), pulse swap_req, wait for swap_done -> vga_r=4'hF, g=b=0 on screen x 20-21, y 10-11; all other pixels show prior bank data; front_sel=1.
3. swap_req at line 100 -> wr_ready=0 until vblank start at line 480, then swap_done for 1 cycle, frame_cnt+1, wr_ready=1 next cycle. Second swap_req while pending does not cause a double toggle.
4. Write (x=320, y=0, 0xFF) -> wr_ready=1, wr_oob=1 and stays 1. A readback scan shows no pixel changed.
5. Assert rst at line 300 with a swap pending -> next edge: rgb=0, h_sync=v_sync=1, front_sel=0, frame_cnt=0, swap_done never fires.
6. (VGA_FB_TESTPAT_EN) tp_en=1 -> screen x 0-79 black; x 560-639 r=g=b=4'hF; sync timing identical to scenario 1.
